// File: rtl/delay_server.sv
// delay_server: several circular delay lines sharing one synchronous-read RAM,
// served one request at a time by a small IDLE/ADDR/MEM/RESP state machine.
module delay_server #(
  parameter int data_width  = 16,
  parameter int n_lines     = 8,
  parameter int buffer_size = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           delay_read_req,
  input  logic                           delay_write_req,
  input  logic [data_width-1:0]          delay_req_handle,
  input  logic [data_width-1:0]          delay_req_arg,
  output logic [data_width-1:0]          delay_req_data_out,
  output logic                           delay_read_ready,
  output logic                           delay_write_ready,
  input  logic                           cfg_write,
  input  logic [$clog2(n_lines)-1:0]     cfg_line,
  input  logic [$clog2(buffer_size)-1:0] cfg_base,
  input  logic [$clog2(buffer_size):0]   cfg_len
);

  localparam int lb = $clog2(n_lines);
  localparam int aw = $clog2(buffer_size);
  localparam int lw = aw + 1;
  localparam int cw = ((data_width > lw) ? data_width : lw) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, MEM, RESP} state_t;

  state_t state_q, state_d;

  logic read_req_q, write_req_q;
  logic read_start, write_start;
  logic pending_read_q, pending_write_q;
  logic take_read, take_write, ram_we, load_addr, cfg_apply;
  logic op_write_q;
  logic [data_width-1:0] handle_q, arg_q;

  logic [aw-1:0] base_q [n_lines];
  logic [lw-1:0] len_q  [n_lines];
  logic [lw-1:0] wptr_q [n_lines];

  logic          cfg_held_q;
  logic [lb-1:0] held_line_q;
  logic [aw-1:0] held_base_q;
  logic [lw-1:0] held_len_q;
  logic [lb-1:0] apply_line;
  logic [aw-1:0] apply_base;
  logic [lw-1:0] apply_len;

  logic [lb-1:0] line_idx;
  logic          line_ok;
  logic [aw-1:0] cur_base;
  logic [lw-1:0] cur_len, cur_wptr, wptr_next;
  logic [cw-1:0] len_m1, dly, wp, offset;
  logic [aw-1:0] rd_addr_d, rd_addr_q, wr_addr;

  logic [data_width-1:0] mem [buffer_size];
  logic [data_width-1:0] ram_q;

  assign read_start  = delay_read_req & ~read_req_q;
  assign write_start = delay_write_req & ~write_req_q;

  // A fresh cfg_write wins over an older held one when both could apply.
  assign apply_line = cfg_write ? cfg_line : held_line_q;
  assign apply_base = cfg_write ? cfg_base : held_base_q;
  assign apply_len  = cfg_write ? cfg_len  : held_len_q;

  assign line_idx = handle_q[lb-1:0];
  assign line_ok  = (handle_q < data_width'(n_lines)) && (len_q[line_idx] != '0);
  assign cur_base = base_q[line_idx];
  assign cur_len  = len_q[line_idx];
  assign cur_wptr = wptr_q[line_idx];

  assign wptr_next = (cur_wptr == cur_len - lw'(1)) ? '0 : cur_wptr + lw'(1);

  // Delay saturates at the oldest sample; the offset wraps back into 0..len-1.
  assign len_m1    = cw'(cur_len) - cw'(1);
  assign dly       = (cw'(arg_q) > len_m1) ? len_m1 : cw'(arg_q);
  assign wp        = cw'(cur_wptr);
  assign offset    = (wp > dly) ? (wp - cw'(1) - dly) : (wp + cw'(cur_len) - cw'(1) - dly);
  assign rd_addr_d = aw'(cw'(cur_base) + offset);
  assign wr_addr   = cur_base + aw'(cur_wptr);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_d    = state_q;
    take_write = 1'b0;
    take_read  = 1'b0;
    ram_we     = 1'b0;
    load_addr  = 1'b0;
    cfg_apply  = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_apply = !pending_read_q && !pending_write_q && (cfg_write || cfg_held_q);
        if (pending_write_q) begin
          take_write = 1'b1;
          state_d    = ADDR;
        end else if (pending_read_q) begin
          take_read = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (op_write_q) begin
          ram_we  = line_ok;
          state_d = RESP;
        end else begin
          load_addr = 1'b1;
          state_d   = MEM;
        end
      end
      MEM:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Previous request levels; reset to 1 so a level already high at release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_req_q  <= 1'b1;
      write_req_q <= 1'b1;
    end else begin
      read_req_q  <= delay_read_req;
      write_req_q <= delay_write_req;
    end
  end

  // Pending flags, latched request, per-line pointers and configuration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_read_q  <= 1'b0;
      pending_write_q <= 1'b0;
      op_write_q      <= 1'b0;
      handle_q        <= '0;
      arg_q           <= '0;
      rd_addr_q       <= '0;
      cfg_held_q      <= 1'b0;
      held_line_q     <= '0;
      held_base_q     <= '0;
      held_len_q      <= '0;
      for (int i = 0; i < n_lines; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        wptr_q[i] <= '0;
      end
    end else begin
      pending_read_q  <= (pending_read_q & ~take_read) | read_start;
      pending_write_q <= (pending_write_q & ~take_write) | write_start;
      if (take_read || take_write) begin
        op_write_q <= take_write;
        handle_q   <= delay_req_handle;
        arg_q      <= delay_req_arg;
      end
      if (load_addr) rd_addr_q <= rd_addr_d;
      if (ram_we) wptr_q[line_idx] <= wptr_next;
      if (cfg_apply) begin
        base_q[apply_line] <= apply_base;
        len_q[apply_line]  <= apply_len;
        wptr_q[apply_line] <= '0;
        cfg_held_q         <= 1'b0;
      end else if (cfg_write) begin
        cfg_held_q  <= 1'b1;
        held_line_q <= cfg_line;
        held_base_q <= cfg_base;
        held_len_q  <= cfg_len;
      end
    end
  end

  // Shared sample RAM with one-cycle synchronous read.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_addr] <= arg_q;
    ram_q <= mem[rd_addr_q];
  end

  // Registered completion pulses and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      delay_read_ready   <= 1'b0;
      delay_write_ready  <= 1'b0;
      delay_req_data_out <= '0;
    end else begin
      delay_read_ready   <= (state_q == RESP) && !op_write_q;
      delay_write_ready  <= (state_q == RESP) && op_write_q;
      delay_req_data_out <= ((state_q == RESP) && !op_write_q && line_ok) ? ram_q : '0;
    end
  end

endmodule

// File: tb/tb_delay_server.sv
// tb_delay_server: directed scenarios plus randomized traffic against a
// line/address-level reference model of the delay server.
module tb_delay_server;

  localparam int data_width  = 16;
  localparam int n_lines     = 8;
  localparam int buffer_size = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        delay_read_req, delay_write_req;
  logic [15:0] delay_req_handle, delay_req_arg;
  logic [15:0] delay_req_data_out;
  logic        delay_read_ready, delay_write_ready;
  logic        cfg_write;
  logic [2:0]  cfg_line;
  logic [11:0] cfg_base;
  logic [12:0] cfg_len;

  int checks = 0;
  int errors = 0;

  int          m_base [n_lines];
  int          m_len  [n_lines];
  int          m_wptr [n_lines];
  logic [15:0] m_mem  [int];

  delay_server #(
    .data_width (data_width),
    .n_lines    (n_lines),
    .buffer_size(buffer_size)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .delay_read_req    (delay_read_req),
    .delay_write_req   (delay_write_req),
    .delay_req_handle  (delay_req_handle),
    .delay_req_arg     (delay_req_arg),
    .delay_req_data_out(delay_req_data_out),
    .delay_read_ready  (delay_read_ready),
    .delay_write_ready (delay_write_ready),
    .cfg_write         (cfg_write),
    .cfg_line          (cfg_line),
    .cfg_base          (cfg_base),
    .cfg_len           (cfg_len)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < n_lines; i++) begin
      m_base[i] = 0;
      m_len[i]  = 0;
      m_wptr[i] = 0;
    end
  endfunction

  function automatic void model_cfg(input int line, input int base, input int len);
    m_base[line] = base;
    m_len[line]  = len;
    m_wptr[line] = 0;
  endfunction

  function automatic void model_write(input int handle, input int arg);
    if (handle >= n_lines || m_len[handle] == 0) return;
    m_mem[(m_base[handle] + m_wptr[handle]) % buffer_size] = 16'(arg);
    m_wptr[handle] = (m_wptr[handle] + 1) % m_len[handle];
  endfunction

  // Returns 1 when the expected read value is known (RAM never written there is unknown).
  function automatic bit model_read(input int handle, input int arg, output logic [15:0] val);
    int d, off, addr;
    val = '0;
    if (handle >= n_lines || m_len[handle] == 0) return 1'b1;
    d    = (arg > m_len[handle] - 1) ? m_len[handle] - 1 : arg;
    off  = ((m_wptr[handle] - 1 - d) % m_len[handle] + m_len[handle]) % m_len[handle];
    addr = (m_base[handle] + off) % buffer_size;
    if (!m_mem.exists(addr)) return 1'b0;
    val = m_mem[addr];
    return 1'b1;
  endfunction

  task automatic wait_ready(input bit is_write, inout int lat, output bit got);
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      got = is_write ? delay_write_ready : delay_read_ready;
    end
  endtask

  task automatic configure(input int line, input int base, input int len);
    @(posedge clk);
    #1;
    cfg_write = 1'b1;
    cfg_line  = 3'(line);
    cfg_base  = 12'(base);
    cfg_len   = 13'(len);
    @(posedge clk);
    #1;
    cfg_write = 1'b0;
    model_cfg(line, base, len);
  endtask

  task automatic applyStimulus(input bit is_write, input int handle, input int arg);
    logic [15:0] exp_val;
    bit known, got;
    int lat;
    known = 1'b0;
    if (!is_write) known = model_read(handle, arg, exp_val);
    @(posedge clk);
    #1;
    delay_req_handle = 16'(handle);
    delay_req_arg    = 16'(arg);
    if (is_write) delay_write_req = 1'b1;
    else          delay_read_req  = 1'b1;
    @(posedge clk);
    lat = 0;
    wait_ready(is_write, lat, got);
    checkOutput(is_write ? "wr_latency" : "rd_latency", lat, is_write ? 3 : 4);
    if (got && !is_write && known) checkOutput("rd_data", delay_req_data_out, exp_val);
    @(posedge clk);
    #1;
    checkOutput("ready_pulse_width", is_write ? delay_write_ready : delay_read_ready, 0);
    delay_read_req  = 1'b0;
    delay_write_req = 1'b0;
    if (is_write) model_write(handle, arg);
  endtask

  // Bounds the whole run in case a wait is never satisfied.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main scenario sequence.
  initial begin
    logic [15:0] exp_val;
    bit got, known;
    int lat, r;

    reset            = 1'b0;
    delay_read_req   = 1'b0;
    delay_write_req  = 1'b0;
    delay_req_handle = '0;
    delay_req_arg    = '0;
    cfg_write        = 1'b0;
    cfg_line         = '0;
    cfg_base         = '0;
    cfg_len          = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_read_ready", delay_read_ready, 0);
    checkOutput("reset_write_ready", delay_write_ready, 0);
    checkOutput("reset_data_out", delay_req_data_out, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] basic write/read on line 2");
    configure(2, 100, 4);
    applyStimulus(1, 2, 10);
    applyStimulus(1, 2, 20);
    applyStimulus(1, 2, 30);
    applyStimulus(0, 2, 0);
    applyStimulus(0, 2, 2);

    $display("[TB] pointer wrap and saturation");
    configure(2, 100, 4);
    for (int v = 1; v <= 6; v++) applyStimulus(1, 2, v);
    applyStimulus(0, 2, 0);
    applyStimulus(0, 2, 3);
    applyStimulus(0, 2, 9);

    $display("[TB] simultaneous read and write edges");
    @(posedge clk);
    #1;
    delay_req_handle = 16'd2;
    delay_req_arg    = 16'd7;
    delay_write_req  = 1'b1;
    delay_read_req   = 1'b1;
    @(posedge clk);
    lat = 0;
    wait_ready(1'b1, lat, got);
    checkOutput("sim_wr_latency", lat, 3);
    checkOutput("sim_rd_not_before_wr", delay_read_ready, 0);
    delay_req_arg = 16'd0;
    wait_ready(1'b0, lat, got);
    checkOutput("sim_rd_latency", lat, 7);
    if (got) checkOutput("sim_rd_data", delay_req_data_out, 7);
    @(posedge clk);
    #1;
    delay_read_req  = 1'b0;
    delay_write_req = 1'b0;
    model_write(2, 7);

    $display("[TB] invalid handle and disabled line");
    applyStimulus(0, 9, 0);
    configure(4, 200, 2);
    applyStimulus(1, 4, 71);
    applyStimulus(1, 4, 72);
    configure(5, 200, 0);
    applyStimulus(1, 5, 999);
    applyStimulus(1, 12, 555);
    applyStimulus(0, 4, 0);
    applyStimulus(0, 4, 1);
    applyStimulus(0, 5, 0);

    $display("[TB] address wrap past the end of the buffer");
    configure(6, 4094, 5);
    for (int v = 1; v <= 5; v++) applyStimulus(1, 6, v);
    applyStimulus(0, 6, 4);
    applyStimulus(0, 6, 0);

    $display("[TB] reset during a read");
    @(posedge clk);
    #1;
    delay_req_handle = 16'd2;
    delay_req_arg    = 16'd0;
    delay_read_req   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midreset_read_ready", delay_read_ready, 0);
    checkOutput("midreset_data_out", delay_req_data_out, 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("inreset_read_ready", delay_read_ready, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("postreset_no_ready", delay_read_ready, 0);
    end
    delay_read_req = 1'b0;
    applyStimulus(0, 2, 0);

    $display("[TB] configuration held while busy");
    configure(3, 300, 4);
    for (int v = 41; v <= 44; v++) applyStimulus(1, 3, v);
    configure(2, 100, 4);
    applyStimulus(1, 2, 11);
    applyStimulus(1, 2, 22);
    known = model_read(2, 0, exp_val);
    @(posedge clk);
    #1;
    delay_req_handle = 16'd2;
    delay_req_arg    = 16'd0;
    delay_read_req   = 1'b1;
    @(posedge clk);
    #1;
    cfg_write = 1'b1;
    cfg_line  = 3'd2;
    cfg_base  = 12'd300;
    cfg_len   = 13'd4;
    @(posedge clk);
    #1;
    cfg_write = 1'b0;
    lat = 1;
    wait_ready(1'b0, lat, got);
    checkOutput("busycfg_rd_latency", lat, 4);
    if (got && known) checkOutput("busycfg_rd_data", delay_req_data_out, exp_val);
    @(posedge clk);
    #1;
    delay_read_req = 1'b0;
    model_cfg(2, 300, 4);
    applyStimulus(0, 2, 0);
    applyStimulus(0, 2, 3);
    applyStimulus(1, 2, 55);
    applyStimulus(0, 3, 0);
    applyStimulus(0, 3, 3);

    $display("[TB] randomized traffic");
    configure(0, 500, 3);
    configure(1, 4090, 8);
    configure(7, 1000, 1);
    for (int n = 0; n < 90; n++) begin
      r = $urandom_range(0, 99);
      if (r < 10)
        configure($urandom_range(0, 7), $urandom_range(0, 4095), $urandom_range(0, 8));
      else if (r < 60)
        applyStimulus(1, $urandom_range(0, 9), $urandom_range(0, 65535));
      else
        applyStimulus(0, $urandom_range(0, 9), $urandom_range(0, 12));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_server.md
DELAY_SERVER -- requirements
Module: delay_server

Interface
REQ-001 Parameter data_width, 16, sample, handle and argument width.
REQ-002 Parameter n_lines, 8, number of delay lines.
REQ-003 Parameter buffer_size, 4096, total sample storage in words, shared by all lines.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 delay_read_req  in  1  read request, rising-edge significant.
REQ-007 delay_write_req  in  1  write request, rising-edge significant.
REQ-008 delay_req_handle  in  data_width  line index; low $clog2(n_lines) bits used, upper bits must be 0.
REQ-009 delay_req_arg  in  data_width  read: delay in samples (unsigned); write: sample value (signed).
REQ-010 delay_req_data_out  out  data_width  read result, valid while delay_read_ready=1.
REQ-011 delay_read_ready  out  1  one-cycle pulse completing a read.
REQ-012 delay_write_ready  out  1  one-cycle pulse completing a write.
REQ-013 cfg_write  in  1  line configuration strobe.
REQ-014 cfg_line  in  $clog2(n_lines)  line being configured.
REQ-015 cfg_base  in  $clog2(buffer_size)  line base address.
REQ-016 cfg_len  in  $clog2(buffer_size)+1  line length in samples; 0 disables the line.

Function
REQ-017 Per line: base, len, wptr (next slot, 0..len-1); storage is one synchronous-read RAM of buffer_size words.
REQ-018 Request start = req high with req low on the previous clk; starts are latched into pending_read/pending_write flags.
REQ-019 States: IDLE, ADDR, MEM, RESP; transitions only on clk.
REQ-020 IDLE: if pending_write, take write (write has priority); else if pending_read, take read; clear the taken flag; latch handle and arg; go to ADDR.
REQ-021 ADDR, read: offset = (wptr - 1 - min(arg, len-1)) mod len; RAM address = base + offset; go to MEM.
REQ-022 ADDR, write: RAM[base + wptr] <= arg; wptr <= (wptr == len-1) ? 0 : wptr+1; go to RESP.
REQ-023 MEM: wait for RAM read data; go to RESP.
REQ-024 RESP: pulse the ready matching the op for exactly one cycle; for a read, drive delay_req_data_out with the RAM word in the same cycle; go to IDLE.
REQ-025 Latency from the rising req edge to the ready pulse: write 3 cycles, read 4 cycles, with the server idle and nothing pending.
REQ-026 A read with arg=0 returns the most recently written sample; arg >= len saturates to len-1 (oldest sample).
REQ-027 Invalid handle (>= n_lines) or len=0: read returns 0 and pulses ready; write does not modify RAM or wptr and pulses ready.
REQ-028 Edges arriving while busy stay pending; one pending flag per direction; a second same-direction edge before service merges into it.
REQ-029 Simultaneous read and write edges: write served first, read served next with no IDLE gap beyond one cycle.
REQ-030 cfg_write is accepted only in IDLE with nothing pending; otherwise it is held and applied at the next such IDLE; it sets base and len and clears wptr to 0; RAM is not cleared.
REQ-031 A cfg_write and a request start in the same IDLE cycle: cfg is applied first and the request uses the new configuration.
REQ-032 base+len beyond buffer_size: the address wraps modulo buffer_size; no error is flagged.

Reset
REQ-033 While reset=0: state IDLE, both ready outputs 0, delay_req_data_out 0, pending flags 0, held cfg cleared, all wptr/base/len 0; RAM contents undefined.
REQ-034 Reset asserted mid-transaction aborts it; no ready pulse follows; a req level already high at release is not an edge.

Verification
REQ-035 Configure line 2 base=100 len=4; write 10,20,30 -> each write_ready 3 cycles after its edge; read arg=0 -> 30, arg=2 -> 10, with read_ready 4 cycles after the edge.
REQ-036 Line 2 len=4, write 1..6 -> wptr wraps; read arg=0 -> 6, arg=3 -> 3, arg=9 -> 3 (saturated).
REQ-037 Read and write edges in the same cycle on line 2 (last sample 6), write value 7 -> write_ready first, then read arg=0 returns 7.
REQ-038 Read handle 9 -> data 0 with read_ready; write to a len=0 line -> write_ready, RAM and wptr unchanged.
REQ-039 Assert reset=0 during MEM of a read -> no read_ready, outputs 0; after release, a new read of an unconfigured line returns 0.
REQ-040 Issue cfg_write during a busy read -> held until IDLE, then wptr=0; the read in flight completes with the old data.
